// File: rtl/sum_arb_pkg.sv
// Shared types for the two-requester shared-adder arbiter.
// Holds the FSM state encoding, requester index type and round-robin pick.
package sum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef logic req_id_t;

  // Single valid wins; on a tie the requester that did not win last time goes.
  function automatic req_id_t pick_grant(input logic v0, input logic v1,
                                         input req_id_t last);
    if (v0 && v1) return ~last;
    else if (v1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/sum_arbiter_if.sv
// Requester, result and handshake bundle between the arbiter and its clients.
interface sum_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req1_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req0_ready;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;
  logic             res_ready;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/sum_arbiter_add_unit.sv
// Ripple-carry adder built from a chain of 1-bit full-adder cells.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Carry out of the most significant cell.
  assign cout = carry[WIDTH];
endmodule

// File: rtl/sum_arbiter.sv
// Round-robin arbiter feeding two requesters into one shared adder.
// Accept in IDLE, add in CALC, hold the result in HOLD until consumed.
module sum_arbiter
  import sum_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sum_arbiter_if.slave  bus
);

  state_t           state;
  req_id_t          last_grant;
  req_id_t          grant_id;
  logic             accept;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;

  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  req_id_t          op_id_p0;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic             res_valid_p1;
  logic [WIDTH-1:0] res_sum_p1;
  logic             res_cout_p1;
  req_id_t          res_id_p1;

  assign grant_id = pick_grant(bus.req0_valid, bus.req1_valid, last_grant);
  assign accept   = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign grant_a  = grant_id ? bus.req1_a : bus.req0_a;
  assign grant_b  = grant_id ? bus.req1_b : bus.req0_b;

  assign bus.req0_ready = accept && (grant_id == 1'b0);
  assign bus.req1_ready = accept && (grant_id == 1'b1);

  add_unit #(.WIDTH(WIDTH)) u_add (
    .a    (op_a_p0),
    .b    (op_b_p0),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_a_p0      <= '0;
      op_b_p0      <= '0;
      op_id_p0     <= 1'b0;
      res_valid_p1 <= 1'b0;
      res_sum_p1   <= '0;
      res_cout_p1  <= 1'b0;
      res_id_p1    <= 1'b0;
    end else begin
      case (state)
        // p0: capture the granted operand pair
        IDLE: begin
          if (accept) begin
            op_a_p0    <= grant_a;
            op_b_p0    <= grant_b;
            op_id_p0   <= grant_id;
            last_grant <= grant_id;
            state      <= CALC;
          end
        end
        // p1: register the shared adder output
        CALC: begin
          res_sum_p1   <= add_sum;
          res_cout_p1  <= add_cout;
          res_id_p1    <= op_id_p0;
          res_valid_p1 <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_p1 <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid_p1;
  assign bus.res_sum   = res_sum_p1;
  assign bus.res_cout  = res_cout_p1;
  assign bus.res_id    = res_id_p1;

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed checks of the shared-adder arbiter at WIDTH=4.
module tb_sum_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sum_arbiter_if #(.WIDTH(4)) bus ();

  sum_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = 4'd0;
    bus.req0_b = 4'd0;
    bus.req1_a = 4'd0;
    bus.req1_b = 4'd0;
    bus.res_ready = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready0 got=%b want=0", bus.req0_ready); end
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready1 got=%b want=0", bus.req1_ready); end
    tick();
    tick();
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b want=0", bus.res_valid); end
    vectors++; if (bus.res_sum !== 4'd0) begin miscompares++; $display("FAIL rst_sum got=%0d want=0", bus.res_sum); end
    vectors++; if (bus.res_cout !== 1'b0) begin miscompares++; $display("FAIL rst_cout got=%b want=0", bus.res_cout); end
    vectors++; if (bus.res_id !== 1'b0) begin miscompares++; $display("FAIL rst_id got=%b want=0", bus.res_id); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_req0();
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd3;
    bus.req0_b = 4'd4;
    bus.res_ready = 1'b1;
    #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL r0_ready got=%b want=1", bus.req0_ready); end
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL r0_other_ready got=%b want=0", bus.req1_ready); end
    tick();
    bus.req0_valid = 1'b0;
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL r0_calc_valid got=%b want=0", bus.res_valid); end
    tick();
    vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL r0_valid got=%b want=1", bus.res_valid); end
    vectors++; if (bus.res_sum !== 4'd7) begin miscompares++; $display("FAIL r0_sum got=%0d want=7", bus.res_sum); end
    vectors++; if (bus.res_cout !== 1'b0) begin miscompares++; $display("FAIL r0_cout got=%b want=0", bus.res_cout); end
    vectors++; if (bus.res_id !== 1'b0) begin miscompares++; $display("FAIL r0_id got=%b want=0", bus.res_id); end
    tick();
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL r0_release got=%b want=0", bus.res_valid); end
  endtask

  task automatic test_single_req1();
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'd9;
    bus.req1_b = 4'd8;
    #1;
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL r1_ready got=%b want=1", bus.req1_ready); end
    vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL r1_other_ready got=%b want=0", bus.req0_ready); end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    vectors++; if (bus.res_sum !== 4'd1) begin miscompares++; $display("FAIL r1_sum got=%0d want=1", bus.res_sum); end
    vectors++; if (bus.res_cout !== 1'b1) begin miscompares++; $display("FAIL r1_cout got=%b want=1", bus.res_cout); end
    vectors++; if (bus.res_id !== 1'b1) begin miscompares++; $display("FAIL r1_id got=%b want=1", bus.res_id); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_sum [2];
    exp_sum[0] = 4'd3;
    exp_sum[1] = 4'd11;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd1;
    bus.req0_b = 4'd2;
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'd5;
    bus.req1_b = 4'd6;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = logic'(i % 2);
      #1;
      vectors++; if (bus.req0_ready !== (exp_id == 1'b0)) begin miscompares++; $display("FAIL rr_ready0[%0d] got=%b want=%b", i, bus.req0_ready, exp_id == 1'b0); end
      vectors++; if (bus.req1_ready !== (exp_id == 1'b1)) begin miscompares++; $display("FAIL rr_ready1[%0d] got=%b want=%b", i, bus.req1_ready, exp_id == 1'b1); end
      tick();
      vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL rr_calc_ready[%0d] got=%b want=00", i, {bus.req0_ready, bus.req1_ready}); end
      tick();
      vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL rr_hold_ready[%0d] got=%b want=00", i, {bus.req0_ready, bus.req1_ready}); end
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL rr_valid[%0d] got=%b want=1", i, bus.res_valid); end
      vectors++; if (bus.res_id !== exp_id) begin miscompares++; $display("FAIL rr_id[%0d] got=%b want=%b", i, bus.res_id, exp_id); end
      vectors++; if (bus.res_sum !== exp_sum[exp_id]) begin miscompares++; $display("FAIL rr_sum[%0d] got=%0d want=%0d", i, bus.res_sum, exp_sum[exp_id]); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_hold_stall();
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd10;
    bus.req0_b = 4'd7;
    bus.res_ready = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'd2;
    bus.req1_b = 4'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got=%b want=1", i, bus.res_valid); end
      vectors++; if ({bus.res_cout, bus.res_sum} !== 5'd17) begin miscompares++; $display("FAIL stall_result[%0d] got=%0d want=17", i, {bus.res_cout, bus.res_sum}); end
      vectors++; if (bus.res_id !== 1'b0) begin miscompares++; $display("FAIL stall_id[%0d] got=%b want=0", i, bus.res_id); end
      vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL stall_ready[%0d] got=%b want=00", i, {bus.req0_ready, bus.req1_ready}); end
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got=%b want=0", bus.res_valid); end
    #1;
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL stall_idle_grant got=%b want=1", bus.req1_ready); end
    bus.req1_valid = 1'b0;
    #1;
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL withdraw_ready got=%b want=0", bus.req1_ready); end
    tick();
    tick();
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL withdraw_served got=%b want=0", bus.res_valid); end
  endtask

  task automatic test_reset_in_hold();
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd15;
    bus.req0_b = 4'd15;
    bus.res_ready = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    vectors++; if ({bus.res_cout, bus.res_sum} !== 5'd30) begin miscompares++; $display("FAIL rh_result got=%0d want=30", {bus.res_cout, bus.res_sum}); end
    rst_n = 1'b0;
    tick();
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rh_valid got=%b want=0", bus.res_valid); end
    vectors++; if (bus.res_sum !== 4'd0) begin miscompares++; $display("FAIL rh_sum got=%0d want=0", bus.res_sum); end
    vectors++; if (bus.res_cout !== 1'b0) begin miscompares++; $display("FAIL rh_cout got=%b want=0", bus.res_cout); end
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rh_no_pulse got=%b want=0", bus.res_valid); end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rh_tie_grant got=%b want=10", {bus.req0_ready, bus.req1_ready}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_exhaustive();
    bus.res_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [4:0] exp;
        exp = 5'(a + b);
        bus.req0_valid = 1'b1;
        bus.req0_a = 4'(a);
        bus.req0_b = 4'(b);
        #1;
        vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL ex_ready a=%0d b=%0d got=%b want=1", a, b, bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        tick();
        vectors++; if ({bus.res_valid, bus.res_cout, bus.res_sum} !== {1'b1, exp}) begin miscompares++; $display("FAIL ex_sum a=%0d b=%0d got=%0d want=%0d", a, b, {bus.res_valid, bus.res_cout, bus.res_sum}, {1'b1, exp}); end
        tick();
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_req0();
    test_single_req1();
    test_round_robin();
    test_hold_stall();
    test_reset_in_hold();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sum_arbiter.md
SUM_ARBITER -- requirements
Module: sum_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result bit width (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operand pair.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  requester 0/1 operands.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  operand pair accepted this cycle.
REQ-007 SHALL have port res_valid  output  1  result held for downstream.
REQ-008 SHALL have port res_sum  output  WIDTH  registered sum, modulo 2^WIDTH.
REQ-009 SHALL have port res_cout  output  1  registered carry-out of the WIDTH-bit add.
REQ-010 SHALL have port res_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port res_ready  input  1  downstream consumes result.

Function
REQ-012 SHALL share one WIDTH-bit ripple-carry adder between both requesters, carry-in fixed 0.
REQ-013 SHALL implement FSM states IDLE, CALC, HOLD.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle only, capture a, b, id into operand registers, go to CALC; else stay.
REQ-015 Arbitration SHALL be round-robin: single valid wins; both valid -> requester other than last_grant wins.
REQ-016 last_grant SHALL update on every accept to the granted index.
REQ-017 reqN_ready SHALL be 0 in CALC and HOLD, and at most one ready SHALL be high per cycle.
REQ-018 CALC: SHALL register adder sum/cout into res_sum/res_cout, set res_valid=1, go to HOLD.
REQ-019 HOLD: res_valid, res_sum, res_cout, res_id SHALL stay stable until res_ready=1; on res_ready go to IDLE with res_valid=0 next cycle.
REQ-020 Latency: accept at cycle N -> res_valid high at N+2; minimum issue interval 3 cycles with res_ready held 1.
REQ-021 Overflow: res_cout=1 iff a+b >= 2^WIDTH; res_sum = low WIDTH bits.
REQ-022 res_ready while res_valid=0 SHALL be ignored.
REQ-023 A requester whose valid drops before grant SHALL not be served; no request is queued internally.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force state IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, last_grant=1, operand registers 0.
REQ-025 reqN_ready SHALL be 0 while rst_n=0.
REQ-026 Reset in CALC or HOLD SHALL discard the in-flight result; no res_valid pulse after reset release until a new accept.

Structure
REQ-027 State enum (IDLE, CALC, HOLD) and requester-index type SHALL live in shared package sum_arb_pkg.
REQ-028 The adder SHALL be a separate sub-module add_unit (parameter WIDTH, inputs a, b, cin; outputs sum, cout) built from 1-bit full-adder cells with a generate loop; cout SHALL be taken from bit WIDTH-1 carry.
REQ-029 Arbiter/FSM and registers SHALL be in sum_arbiter; target 120-400 RTL lines total.

Verification (WIDTH=4)
REQ-030 Single req0 a=3,b=4, res_ready=1 -> req0_ready pulse at N, res_valid at N+2 with sum=7, cout=0, id=0.
REQ-031 req1 a=9,b=8 -> sum=1, cout=1, id=1.
REQ-032 Both valid continuously after reset, res_ready=1 -> grants 0,1,0,1; one ready per cycle max.
REQ-033 res_ready=0 for 5 cycles in HOLD -> res_* stable, both readys 0, no new grant; res_ready=1 -> IDLE.
REQ-034 Reset asserted in HOLD with a=15,b=15 -> res_valid=0 next cycle, res_sum=0, last_grant=1 (next tie grants req0).
REQ-035 Exhaustive 256 operand pairs via req0 -> {cout,sum} equals a+b every transaction.
